vertex_serializer: RTL and testbench

- Front end of the vertex transform path: accepts whole vertices (x, y, z as signed M-bit integers) on a valid/ready interface.
- Buffers them in a small FIFO and converts each to Q(M).(N) fixed point with an implicit w = 1.0.
- Emits the four components as a serial component stream (x, y, z, w order, one per cycle, with a valid strobe) for the vertex processor.
- Also generates zero padding on request, because the processor pipeline only advances on valid beats and must be flushed to drain its last result.

---
 rtl/vertex_pkg.sv | 16 +
 rtl/vertex_fifo.sv | 44 ++++
 rtl/vertex_serializer.sv | 171 +++++++++++++++++
 tb/tb_vertex_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vertex_pkg.sv
// Shared types for the vertex serializer: default widths, component type,
// FSM state encoding and the component index.
package vertex_pkg;
    localparam int M_DEF = 11;
    localparam int N_DEF = 7;

    typedef logic signed [M_DEF+N_DEF-1:0] component_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef logic [1:0] comp_idx_t;
endpackage

// File: rtl/vertex_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers; the head entry is always
// visible on rd_data so a pop and its data use happen in the same cycle.
module vertex_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop && !empty)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/vertex_serializer.sv
// Buffers whole vertices, converts them to fixed point with w = 1.0 and
// streams x, y, z, w one per cycle; also emits zero padding on flush.
module vertex_serializer
    import vertex_pkg::*;
#(
    parameter int M           = M_DEF,
    parameter int N           = N_DEF,
    parameter int DEPTH       = 4,
    parameter int FLUSH_BEATS = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [M-1:0]   s_x,
    input  logic [M-1:0]   s_y,
    input  logic [M-1:0]   s_z,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic           flush,
    output logic [M+N-1:0] out_component,
    output logic           out_valid,
    output logic           out_pad,
    output logic           flush_done,
    output logic           busy
);
    localparam int CW = M + N;
    localparam int VW = 3 * M;
    localparam int FW = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;
    localparam logic [CW-1:0] W_ONE = {{(M-1){1'b0}}, 1'b1, {N{1'b0}}};
    localparam logic [FW-1:0] LAST_BEAT = FW'(FLUSH_BEATS - 1);

    // Sign extension followed by a left shift of N is exactly v with N zero LSBs.
    function automatic logic [CW-1:0] to_fixed(input logic [M-1:0] v);
        return {v, {N{1'b0}}};
    endfunction

    state_t        state_reg;
    comp_idx_t     idx_reg;
    logic [M-1:0]  hold_y_reg;
    logic [M-1:0]  hold_z_reg;
    logic [FW-1:0] flush_cnt_reg;
    logic          flush_pending_reg;
    logic [CW-1:0] out_component_reg;
    logic          out_valid_reg;
    logic          out_pad_reg;
    logic          flush_done_reg;

    logic          fifo_full;
    logic          fifo_empty;
    logic [VW-1:0] fifo_rd_data;
    logic          push;
    logic          pop;
    logic [M-1:0]  head_x;
    logic [M-1:0]  head_y;
    logic [M-1:0]  head_z;
    logic [CW-1:0] next_component;

    assign s_ready = !fifo_full;
    assign push    = s_valid && !fifo_full;
    // Pops happen only at vertex boundaries; never while padding.
    assign pop     = !fifo_empty &&
                     ((state_reg == IDLE) || (state_reg == SEND && idx_reg == 2'd3));

    assign head_x = fifo_rd_data[VW-1 -: M];
    assign head_y = fifo_rd_data[2*M-1 -: M];
    assign head_z = fifo_rd_data[M-1:0];

    vertex_fifo #(
        .WIDTH (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (reset),
        .push    (push),
        .wr_data ({s_x, s_y, s_z}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        next_component = W_ONE;
        case (idx_reg)
            2'd0:    next_component = to_fixed(hold_y_reg);
            2'd1:    next_component = to_fixed(hold_z_reg);
            default: next_component = W_ONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            idx_reg           <= '0;
            hold_y_reg        <= '0;
            hold_z_reg        <= '0;
            flush_cnt_reg     <= '0;
            flush_pending_reg <= 1'b0;
            out_component_reg <= '0;
            out_valid_reg     <= 1'b0;
            out_pad_reg       <= 1'b0;
            flush_done_reg    <= 1'b0;
        end else begin
            flush_done_reg <= 1'b0;
            if (flush && state_reg != FLUSH)
                flush_pending_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (flush_pending_reg && fifo_empty) begin
                        state_reg         <= FLUSH;
                        flush_cnt_reg     <= '0;
                        out_component_reg <= '0;
                        out_valid_reg     <= 1'b1;
                        out_pad_reg       <= 1'b1;
                    end else if (pop) begin
                        state_reg         <= SEND;
                        idx_reg           <= '0;
                        hold_y_reg        <= head_y;
                        hold_z_reg        <= head_z;
                        out_component_reg <= to_fixed(head_x);
                        out_valid_reg     <= 1'b1;
                    end else begin
                        out_component_reg <= '0;
                        out_valid_reg     <= 1'b0;
                    end
                end

                SEND: begin
                    if (idx_reg != 2'd3) begin
                        idx_reg           <= idx_reg + 2'd1;
                        out_component_reg <= next_component;
                    end else if (pop) begin
                        idx_reg           <= '0;
                        hold_y_reg        <= head_y;
                        hold_z_reg        <= head_z;
                        out_component_reg <= to_fixed(head_x);
                    end else begin
                        state_reg         <= IDLE;
                        idx_reg           <= '0;
                        out_component_reg <= '0;
                        out_valid_reg     <= 1'b0;
                    end
                end

                FLUSH: begin
                    if (flush_cnt_reg == LAST_BEAT) begin
                        state_reg         <= IDLE;
                        flush_pending_reg <= 1'b0;
                        flush_done_reg    <= 1'b1;
                        out_valid_reg     <= 1'b0;
                        out_pad_reg       <= 1'b0;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_pad_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign out_component = out_component_reg;
    assign out_valid     = out_valid_reg;
    assign out_pad       = out_pad_reg;
    assign flush_done    = flush_done_reg;
    assign busy          = !fifo_empty || (state_reg != IDLE) || flush_pending_reg;
endmodule

// File: tb/tb_vertex_serializer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and
// compares every valid output beat and every flush_done pulse.
module tb_vertex_serializer;
    localparam int M  = 11;
    localparam int N  = 7;
    localparam int CW = M + N;
    localparam int FLUSH_BEATS = 8;

    typedef struct {
        logic          pad;
        logic [CW-1:0] comp;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [M-1:0]  s_x = '0;
    logic [M-1:0]  s_y = '0;
    logic [M-1:0]  s_z = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          flush = 1'b0;
    logic [CW-1:0] out_component;
    logic          out_valid;
    logic          out_pad;
    logic          flush_done;
    logic          busy;

    int total = 0;
    int bad = 0;
    beat_t exp_q[$];
    int exp_done = 0;
    int done_seen = 0;
    int pad_run = 0;
    bit prev_pad = 1'b0;
    int cur_run = 0;
    int max_run = 0;

    vertex_serializer #(.M(M), .N(N), .DEPTH(4), .FLUSH_BEATS(FLUSH_BEATS)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_x           (s_x),
        .s_y           (s_y),
        .s_z           (s_z),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .flush         (flush),
        .out_component (out_component),
        .out_valid     (out_valid),
        .out_pad       (out_pad),
        .flush_done    (flush_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion: the integer value scaled by 2^N, kept to CW bits.
    function automatic logic [CW-1:0] model_conv(input int v);
        int p;
        p = v * (1 << N);
        return p[CW-1:0];
    endfunction

    task automatic expect_vertex(input int x, input int y, input int z);
        exp_q.push_back('{1'b0, model_conv(x)});
        exp_q.push_back('{1'b0, model_conv(y)});
        exp_q.push_back('{1'b0, model_conv(z)});
        exp_q.push_back('{1'b0, model_conv(1)});
        $display("vertex accepted x=%0d y=%0d z=%0d", x, y, z);
    endtask

    task automatic expect_pads();
        for (int i = 0; i < FLUSH_BEATS; i++)
            exp_q.push_back('{1'b1, '0});
        exp_done++;
        $display("flush expected: %0d pad beats", FLUSH_BEATS);
    endtask

    // Offers one vertex; returns just after the accepting edge.
    task automatic drive_vertex(input int x, input int y, input int z);
        int  xv, yv, zv;
        bit  rdy;
        bit  done;
        xv = x; yv = y; zv = z;
        done = 1'b0;
        @(negedge clk);
        s_x = xv[M-1:0];
        s_y = yv[M-1:0];
        s_z = zv[M-1:0];
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = s_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else @(negedge clk);
        end
        #1 s_valid = 1'b0;
        if (done) expect_vertex(x, y, z);
        else check("handshake_timeout", 0, 1);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        check("drain", ok, 1);
        repeat (3) @(negedge clk);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("beat comp=%0d pad=%0d", $signed(out_component), out_pad);
                check("component", $signed(out_component), $signed(e.comp));
                check("pad_flag", out_pad, e.pad);
            end
        end else begin
            check("idle_zero", out_component, 0);
        end
        if (flush_done) begin
            check("done_after_pad", prev_pad, 1);
            check("pad_run_len", pad_run, FLUSH_BEATS);
            done_seen++;
            pad_run = 0;
        end
        if (out_valid && out_pad) pad_run++;
        if (out_valid && !out_pad) cur_run++;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
        prev_pad = out_valid && out_pad;
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pad", out_pad, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_component", out_component, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);

        // Single vertex with latency check: x in cycle t+2.
        drive_vertex(3, -2, 0);
        @(posedge clk);
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        check("latency_x", $signed(out_component), 384);
        wait_drain();

        // Five back-to-back vertices: FIFO fills, 20 contiguous beats.
        max_run = 0;
        for (int v = 0; v < 5; v++)
            drive_vertex(v * 100 - 200, -v - 1, v * 7);
        @(negedge clk);
        check("full_stall", s_ready, 0);
        wait_drain();
        check("contiguous_run", max_run, 20);

        // Extremes.
        drive_vertex(-1024, 1023, -1);
        wait_drain();

        // Flush during the y beat of a vertex.
        drive_vertex(5, 6, 7);
        @(posedge clk);
        @(posedge clk);
        pulse_flush();
        expect_pads();
        wait_drain();

        // Flush, then a vertex accepted before padding, then a flush during FLUSH.
        drive_vertex(11, -12, 13);
        pulse_flush();
        drive_vertex(-21, 22, -23);
        expect_pads();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_pad) seen = 1'b1;
        end
        check("pad_started", seen, 1);
        pulse_flush();
        wait_drain();

        // Reset on the z beat aborts the vertex.
        drive_vertex(40, 41, 42);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_s_ready", s_ready, 1);
        check("abort_busy", busy, 0);
        drive_vertex(-7, 8, -9);
        wait_drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            int  x, y, z;
            bit  v, rdy;
            @(negedge clk);
            x = int'($urandom_range(0, 2047)) - 1024;
            y = int'($urandom_range(0, 2047)) - 1024;
            z = int'($urandom_range(0, 2047)) - 1024;
            v = ($urandom_range(0, 2) != 0);
            s_x = x[M-1:0];
            s_y = y[M-1:0];
            s_z = z[M-1:0];
            s_valid = v;
            rdy = s_ready;
            @(posedge clk);
            if (v && rdy) expect_vertex(x, y, z);
        end
        #1 s_valid = 1'b0;
        wait_drain();

        check("flush_done_count", done_seen, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
